// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: arbitrates NCH requesters onto a byte-serial 8-bit RAM/IO bus,
// serialising 1/2/4-byte accesses and assembling extended load results.
module mem_arbiter #(
  parameter int unsigned     NCH        = 2,
  parameter int unsigned     ARB_MODE   = 1,
  parameter logic [NCH-1:0]  FLUSH_MASK = (NCH)'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              io_buffer_full,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [32*NCH-1:0] addr,
  input  logic [32*NCH-1:0] wdata,
  input  logic [2*NCH-1:0]  size,
  input  logic [NCH-1:0]    sext,
  output logic [NCH-1:0]    ack,
  output logic [31:0]       rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_IOWAIT, S_XFER, S_RDTAIL, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   id_q, id_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      nlast_q, nlast_d;
  logic            sext_q, sext_d;
  logic [2:0]      k_q, k_d;
  logic            pend_q, pend_d;
  logic [31:0]     buf_q, buf_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [NCH-1:0]  ack_q, ack_d;

  logic [NCH-1:0]  cand;
  logic            gnt_valid;
  logic [IW-1:0]   gnt_id;
  int unsigned     scan_start;
  int unsigned     scan_idx;
  logic [31:0]     addr_sel;
  logic [31:0]     wdata_sel;
  logic [1:0]      size_sel;
  logic [1:0]      cap_idx;
  logic            abort;

  // Pick the winning channel; the channel being acked and, during clear, flushable channels are skipped.
  always_comb begin
    cand = req & ~ack_q;
    if (clear) cand = cand & ~FLUSH_MASK;
    scan_start = (ARB_MODE == 1) ? 32'(rr_q) : 32'd0;
    scan_idx   = 0;
    gnt_valid  = 1'b0;
    gnt_id     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      scan_idx = (scan_start + i) % NCH;
      if (!gnt_valid && cand[scan_idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = IW'(scan_idx);
      end
    end
    addr_sel  = addr[32*gnt_id +: 32];
    wdata_sel = wdata[32*gnt_id +: 32];
    size_sel  = size[2*gnt_id +: 2];
  end

  // Next-state logic. A freeze with a read byte in flight rolls k back by one
  // so that byte is fetched again once rdy returns.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    nlast_d = nlast_q;
    sext_d  = sext_q;
    k_d     = k_q;
    pend_d  = pend_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    ack_d   = ack_q;
    cap_idx = k_q[1:0] - 2'd1;
    abort   = clear && !we_q && FLUSH_MASK[id_q] && (addr_q[17:16] != 2'b11);
    if (rdy) begin
      ack_d  = '0;
      pend_d = 1'b0;
      if (pend_q) buf_d[8*cap_idx +: 8] = mem_din;
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            id_d    = gnt_id;
            we_d    = we[gnt_id];
            addr_d  = addr_sel;
            wdata_d = wdata_sel;
            sext_d  = sext[gnt_id];
            nlast_d = (size_sel == 2'd0) ? 2'd0 : (size_sel == 2'd1) ? 2'd1 : 2'd3;
            k_d     = '0;
            buf_d   = '0;
            if (ARB_MODE == 1) rr_d = (gnt_id == IW'(NCH - 1)) ? '0 : gnt_id + 1'b1;
            if (we[gnt_id] && (addr_sel[17:16] == 2'b11) && io_buffer_full) state_d = S_IOWAIT;
            else state_d = S_XFER;
          end
        end
        S_IOWAIT: begin
          if (!io_buffer_full) state_d = S_XFER;
        end
        S_XFER: begin
          if (abort) begin
            state_d = S_IDLE;
          end else begin
            k_d    = k_q + 3'd1;
            pend_d = !we_q;
            if (k_q[1:0] == nlast_q) begin
              state_d = we_q ? S_DONE : S_RDTAIL;
              if (we_q) ack_d[id_q] = 1'b1;
            end
          end
        end
        S_RDTAIL: begin
          state_d = S_IDLE;
          if (!abort) begin
            case (nlast_q)
              2'd0:    rdata_d = {{24{sext_q & buf_d[7]}}, buf_d[7:0]};
              2'd1:    rdata_d = {{16{sext_q & buf_d[15]}}, buf_d[15:0]};
              default: rdata_d = buf_d;
            endcase
            ack_d[id_q] = 1'b1;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end else if (pend_q) begin
      k_d    = k_q - 3'd1;
      pend_d = 1'b0;
      if (state_q == S_RDTAIL) state_d = S_XFER;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      nlast_q <= '0;
      sext_q  <= 1'b0;
      k_q     <= '0;
      pend_q  <= 1'b0;
      buf_q   <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      nlast_q <= nlast_d;
      sext_q  <= sext_d;
      k_q     <= k_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  // Bus drive: only active during XFER; writes are suppressed while frozen.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (state_q == S_XFER) begin
      mem_a = addr_q + {30'd0, k_q[1:0]};
      if (we_q) begin
        mem_dout = wdata_q[8*k_q[1:0] +: 8];
        mem_wr   = rdy;
      end
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_arbiter: byte-serial reads/writes, extension, IO
// back-pressure, arbitration order, flush, freeze and async reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, io_full;
  logic [1:0]  req, we, sext;
  logic [63:0] addr, wdata;
  logic [3:0]  size;
  logic [1:0]  ack, ack_f;
  logic [31:0] rdata, rdata_f, mem_a, mem_a_f;
  logic [7:0]  mem_din, mem_dout, mem_dout_f;
  logic        mem_wr, mem_wr_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.NCH(2), .ARB_MODE(1), .FLUSH_MASK(2'b01)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .io_buffer_full(io_full),
    .req(req), .we(we), .addr(addr), .wdata(wdata), .size(size), .sext(sext),
    .ack(ack), .rdata(rdata), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  mem_arbiter #(.NCH(2), .ARB_MODE(0), .FLUSH_MASK(2'b01)) dut_f (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .io_buffer_full(io_full),
    .req(req), .we(we), .addr(addr), .wdata(wdata), .size(size), .sext(sext),
    .ack(ack_f), .rdata(rdata_f), .mem_din(mem_din), .mem_dout(mem_dout_f),
    .mem_a(mem_a_f), .mem_wr(mem_wr_f)
  );

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100:  ram_byte = 8'h11;
      32'h101:  ram_byte = 8'h22;
      32'h102:  ram_byte = 8'h33;
      32'h103:  ram_byte = 8'h44;
      32'h8002: ram_byte = 8'h80;
      default:  ram_byte = a[7:0];
    endcase
  endfunction

  // RAM returns the addressed byte one cycle later.
  always @(posedge clk) mem_din <= ram_byte(mem_a);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int ch, input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      step();
      n++;
      if (ack[ch]) break;
    end
  endtask

  // Requester drops req the cycle after ack; no further ack may follow.
  task automatic drop_and_quiet(input int ch, input string tag);
    int cnt;
    step();
    req[ch] = 1'b0;
    cnt = 0;
    repeat (8) begin
      step();
      if (ack[ch]) cnt++;
    end
    chk(tag, cnt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n, wrc, ackc, ackat, cnt, cnt_f;
    logic [7:0]  dout_seen;
    logic [31:0] a_seen, wacc;
    logic [15:0] gseq, gseq_f;
    logic seen, got;

    rst = 1'b0; rdy = 1'b0; clear = 1'b0; io_full = 1'b0;
    req = '0; we = '0; sext = '0; addr = '0; wdata = '0; size = '0;
    step(); step();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_dout", 32'(mem_dout), 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b1; rdy = 1'b1;
    step();

    // Word read ch0 @0x100
    addr[31:0] = 32'h100; size[1:0] = 2'd2; we[0] = 1'b0; sext[0] = 1'b0; req[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("word_rd_mem_a", mem_a, 32'h100 + 32'(j));
      chk("word_rd_mem_wr", 32'(mem_wr), 0);
    end
    wait_ack(0, 10, n);
    chk("word_rd_latency", 32'(n + 4), 6);
    chk("word_rd_rdata", rdata, 32'h44332211);
    drop_and_quiet(0, "word_rd_single_ack");

    // Signed byte read ch1 @0x80
    addr[63:32] = 32'h80; size[3:2] = 2'd0; we[1] = 1'b0; sext[1] = 1'b1; req[1] = 1'b1;
    wait_ack(1, 10, n);
    chk("sbyte_latency", 32'(n), 3);
    chk("sbyte_rdata", rdata, 32'hFFFFFF80);
    drop_and_quiet(1, "sbyte_single_ack");

    // Unsigned half read ch1 @0x8001
    addr[63:32] = 32'h8001; size[3:2] = 2'd1; sext[1] = 1'b0; req[1] = 1'b1;
    wait_ack(1, 10, n);
    chk("uhalf_latency", 32'(n), 4);
    chk("uhalf_rdata", rdata, 32'h00008001);
    drop_and_quiet(1, "uhalf_single_ack");

    // IO write with back-pressure
    addr[63:32] = 32'h30000; wdata[39:32] = 8'h41; size[3:2] = 2'd0; we[1] = 1'b1;
    io_full = 1'b1; req[1] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk("io_no_wr_while_full", 32'(mem_wr), 0);
      step();
    end
    io_full = 1'b0;
    wrc = 0; ackc = 0; dout_seen = '0; a_seen = '0;
    for (int j = 0; j < 10; j++) begin
      if (mem_wr) begin wrc++; dout_seen = mem_dout; a_seen = mem_a; end
      if (ack[1]) begin ackc++; req[1] = 1'b0; end
      step();
    end
    chk("io_wr_count", 32'(wrc), 1);
    chk("io_wr_dout", 32'(dout_seen), 32'h41);
    chk("io_wr_addr", a_seen, 32'h30000);
    chk("io_ack_count", 32'(ackc), 1);

    // Arbitration: both channels keep requesting byte writes
    rst = 1'b0; step(); rst = 1'b1;
    we = 2'b11; size = '0; addr = {32'h500, 32'h400}; wdata = '0; req = 2'b11;
    gseq = '0; gseq_f = '0; cnt = 0; cnt_f = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (ack != 2'b00) begin gseq = {gseq[11:0], (ack == 2'b10) ? 4'd1 : 4'd0}; cnt++; end
      if (ack_f != 2'b00) begin gseq_f = {gseq_f[11:0], (ack_f == 2'b10) ? 4'd1 : 4'd0}; cnt_f++; end
    end
    req = '0;
    chk("rr_grant_seq", 32'(gseq), 32'h0101);
    chk("rr_grant_cnt", 32'(cnt), 4);
    chk("fixed_grant_seq", 32'(gseq_f), 32'h0000);
    chk("fixed_grant_cnt", 32'(cnt_f), 4);
    step(); step(); step();

    // Flush aborts a ch0 word read at k=2
    we = '0; addr[31:0] = 32'h200; size[1:0] = 2'd2; req = 2'b01;
    step(); step(); step();
    chk("flush_rd_k2_addr", mem_a, 32'h202);
    clear = 1'b1; req[0] = 1'b0;
    step();
    clear = 1'b0;
    chk("flush_rd_idle", mem_a, 0);
    cnt = 0;
    repeat (8) begin step(); if (ack[0]) cnt++; end
    chk("flush_rd_no_ack", 32'(cnt), 0);

    // Flush during a ch1 word store does not stop it
    we[1] = 1'b1; addr[63:32] = 32'h600; wdata[63:32] = 32'hA1B2C3D4; size[3:2] = 2'd2; req = 2'b10;
    wrc = 0; wacc = '0; ackat = -1;
    for (int j = 0; j < 10; j++) begin
      clear = (j == 2);
      if (mem_wr && wrc < 4) begin wacc[8*wrc +: 8] = mem_dout; wrc++; end
      if (ack[1] && ackat < 0) begin ackat = j; req[1] = 1'b0; end
      step();
    end
    clear = 1'b0;
    chk("flush_wr_count", 32'(wrc), 4);
    chk("flush_wr_data", wacc, 32'hA1B2C3D4);
    chk("flush_wr_ack_cycle", 32'(ackat), 5);

    // Freeze mid-read
    we = '0; addr[31:0] = 32'h100; size[1:0] = 2'd2; sext = '0; req = 2'b01;
    step();
    chk("frz_k0_addr", mem_a, 32'h100);
    step();
    rdy = 1'b0;
    repeat (3) begin
      chk("frz_no_wr", 32'(mem_wr), 0);
      chk("frz_no_ack", 32'(ack), 0);
      step();
    end
    rdy = 1'b1;
    seen = 1'b0; got = 1'b0;
    for (int j = 0; j < 15; j++) begin
      if (mem_a == 32'h101) seen = 1'b1;
      if (ack[0]) begin got = 1'b1; break; end
      step();
    end
    chk("frz_byte1_reissued", 32'(seen), 1);
    chk("frz_ack", 32'(got), 1);
    chk("frz_rdata", rdata, 32'h44332211);
    drop_and_quiet(0, "frz_single_ack");

    // Async reset mid-write
    we[1] = 1'b1; addr[63:32] = 32'h700; wdata[63:32] = 32'h55667788; size[3:2] = 2'd2; req = 2'b10;
    step(); step();
    chk("rstw_writing", 32'(mem_wr), 1);
    #1 rst = 1'b0;
    #1;
    chk("rstw_mem_wr", 32'(mem_wr), 0);
    chk("rstw_mem_a", mem_a, 0);
    chk("rstw_mem_dout", 32'(mem_dout), 0);
    chk("rstw_ack", 32'(ack), 0);
    req = '0;
    step();
    rst = 1'b1;
    cnt = 0;
    repeat (6) begin step(); if (mem_wr || mem_a != 0) cnt++; end
    chk("rstw_idle_after", 32'(cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
